// File: rtl/controlador_acesso_senha_pkg.sv
// Shared types and constants for the password access controller.
// The entry word holds 20 BCD-style nibbles; nibble 0 is the most recent key.
package controlador_acesso_senha_pkg;

  localparam int N_DIGITOS = 20;

  typedef logic [4*N_DIGITOS-1:0] senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA   = {N_DIGITOS{4'hF}};
  localparam senhaPac_t SENHA_CANCELA = {N_DIGITOS{4'hB}};
  localparam senhaPac_t SENHA_TIMEOUT = {N_DIGITOS{4'hE}};

  typedef enum logic [2:0] {
    OCIOSO,
    VERIFICA,
    ABERTO,
    FALHA,
    BLOQUEIO
  } estado_acesso_t;

endpackage

// File: rtl/controlador_acesso_senha_comparador.sv
// Combinational comparison of one submitted entry against one stored slot.
// match: identical words and the slot is not empty; len_ok: digit run is well formed and of legal length.
module comparador_senha
  import controlador_acesso_senha_pkg::*;
#(
  parameter int MIN_DIG = 4,
  parameter int MAX_DIG = 12
) (
  input  senhaPac_t entrada,
  input  senhaPac_t senha,
  output logic      match,
  output logic      len_ok
);

  localparam logic [4:0] MIN_LEN = 5'(MIN_DIG);
  localparam logic [4:0] MAX_LEN = 5'(MAX_DIG);

  logic [4:0] len;
  logic       em_sequencia;
  logic       invalido;
  logic [3:0] nib;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every variable a default first, so no latch is inferred.
    len          = '0;
    em_sequencia = 1'b1;
    invalido     = 1'b0;
    nib          = 4'hF;
    // Length is the run of non-F nibbles starting at the newest key.
    for (int i = 0; i < N_DIGITOS; i++) begin
      nib = entrada[4*i +: 4];
      if (em_sequencia) begin
        if (nib == 4'hF) begin
          em_sequencia = 1'b0;
        end else begin
          len = len + 5'd1;
          if (nib > 4'h9) invalido = 1'b1;
        end
      end
    end
    len_ok = !invalido && (len >= MIN_LEN) && (len <= MAX_LEN);
    match  = (entrada == senha) && (senha != SENHA_VAZIA);
  end

endmodule

// File: rtl/controlador_acesso_senha.sv
// Access controller: scans stored passwords one slot per cycle, then sequences
// the unlock hold, failed-attempt counting and keypad lockout.
module controlador_acesso_senha
  import controlador_acesso_senha_pkg::*;
#(
  parameter int N_SENHAS   = 4,
  parameter int MAX_TENT   = 3,
  parameter int T_ABERTO   = 5000,
  parameter int T_BLOQUEIO = 30000,
  parameter int MIN_DIG    = 4,
  parameter int MAX_DIG    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  senhaPac_t                     digitos_value,
  input  logic                          digitos_valid,
  input  logic                          cfg_we,
  input  logic [$clog2(N_SENHAS)-1:0]   cfg_idx,
  input  senhaPac_t                     cfg_senha,
  output logic                          teclado_en,
  output logic                          tranca_abrir,
  output logic                          erro,
  output logic                          bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0] tentativas
);

  localparam int T_MAX  = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
  localparam int TMR_W  = $clog2(T_MAX + 1);
  localparam int IDX_W  = $clog2(N_SENHAS);
  localparam int TENT_W = $clog2(MAX_TENT + 1);

  localparam logic [IDX_W-1:0]  ULTIMO_SLOT   = IDX_W'(N_SENHAS - 1);
  localparam logic [TENT_W-1:0] TENT_MAX      = TENT_W'(MAX_TENT);
  localparam logic [TMR_W-1:0]  CARGA_ABERTO  = TMR_W'(T_ABERTO - 1);
  localparam logic [TMR_W-1:0]  CARGA_BLOQUEI = TMR_W'(T_BLOQUEIO - 1);

  estado_acesso_t      estado_q, estado_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TENT_W-1:0]   tent_q, tent_d;
  logic [TENT_W-1:0]   tent_inc;
  senhaPac_t           entrada_q, entrada_d;
  senhaPac_t           slots_q [N_SENHAS];
  senhaPac_t           slots_d [N_SENHAS];

  logic slot_match;
  logic slot_len_ok;
  logic entrada_aceita;

  comparador_senha #(
    .MIN_DIG (MIN_DIG),
    .MAX_DIG (MAX_DIG)
  ) u_comparador (
    .entrada (entrada_q),
    .senha   (slots_q[idx_q]),
    .match   (slot_match),
    .len_ok  (slot_len_ok)
  );

  // Cancel and timeout words from the decoder are not attempts.
  assign entrada_aceita = digitos_valid
                       && (digitos_value != SENHA_CANCELA)
                       && (digitos_value != SENHA_TIMEOUT);

  assign tent_inc = (tent_q == TENT_MAX) ? tent_q : tent_q + 1'b1;

  // Slot writes land at the clock edge, so a slot compared this cycle still shows its old value.
  always_comb begin
    slots_d = slots_q;
    if (cfg_we) slots_d[cfg_idx] = cfg_senha;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every flop samples pre-edge values.
    if (rst) estado_q <= OCIOSO;
    else     estado_q <= estado_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      idx_q     <= '0;
      tent_q    <= '0;
      entrada_q <= SENHA_VAZIA;
      // NOTE: the slot array is deliberately reset: an empty slot must never match after reset.
      for (int i = 0; i < N_SENHAS; i++) slots_q[i] <= SENHA_VAZIA;
    end else begin
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      tent_q    <= tent_d;
      entrada_q <= entrada_d;
      slots_q   <= slots_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    tent_d    = tent_q;
    entrada_d = entrada_q;
    unique case (estado_q)
      OCIOSO: begin
        if (entrada_aceita) begin
          entrada_d = digitos_value;
          idx_d     = '0;
          timer_d   = '0;
          estado_d  = VERIFICA;
        end
      end
      VERIFICA: begin
        if (slot_match && slot_len_ok) begin
          timer_d  = CARGA_ABERTO;
          tent_d   = '0;
          estado_d = ABERTO;
        end else if (idx_q == ULTIMO_SLOT) begin
          timer_d  = '0;
          estado_d = FALHA;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ABERTO: begin
        if (timer_q == '0) begin
          estado_d = OCIOSO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      FALHA: begin
        tent_d = tent_inc;
        if (tent_inc == TENT_MAX) begin
          timer_d  = CARGA_BLOQUEI;
          estado_d = BLOQUEIO;
        end else begin
          timer_d  = '0;
          estado_d = OCIOSO;
        end
      end
      BLOQUEIO: begin
        if (timer_q == '0) begin
          tent_d   = '0;
          estado_d = OCIOSO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        timer_d  = '0;
        estado_d = OCIOSO;
      end
    endcase
  end

  always_comb begin
    teclado_en   = 1'b0;
    tranca_abrir = 1'b0;
    erro         = 1'b0;
    bloqueado    = 1'b0;
    unique case (estado_q)
      OCIOSO:   teclado_en   = 1'b1;
      VERIFICA: ;
      ABERTO:   tranca_abrir = 1'b1;
      FALHA:    erro         = 1'b1;
      BLOQUEIO: bloqueado    = 1'b1;
      default:  teclado_en   = 1'b0;
    endcase
  end

  assign tentativas = tent_q;

endmodule

// File: tb/tb_controlador_acesso_senha.sv
// Self-checking bench: directed vector table, hand-written multi-cycle sequences,
// and a randomized phase compared against a timeline reference model.
module tb_controlador_acesso_senha;
  import controlador_acesso_senha_pkg::*;

  localparam int N    = 4;
  localparam int MAXT = 3;
  localparam int TAB  = 20;
  localparam int TBL  = 40;
  localparam int MIND = 4;
  localparam int MAXD = 12;
  localparam int NR   = 2500;
  localparam int NC   = NR + TAB + TBL + 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  senhaPac_t  digitos_value = SENHA_VAZIA;
  logic       digitos_valid = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = 2'd0;
  senhaPac_t  cfg_senha = SENHA_VAZIA;
  logic       teclado_en, tranca_abrir, erro, bloqueado;
  logic [1:0] tentativas;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_acesso_senha #(
    .N_SENHAS   (N),
    .MAX_TENT   (MAXT),
    .T_ABERTO   (TAB),
    .T_BLOQUEIO (TBL),
    .MIN_DIG    (MIND),
    .MAX_DIG    (MAXD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_senha     (cfg_senha),
    .teclado_en    (teclado_en),
    .tranca_abrir  (tranca_abrir),
    .erro          (erro),
    .bloqueado     (bloqueado),
    .tentativas    (tentativas)
  );

  typedef struct {
    senhaPac_t e;
    int        kind;   // 0 ignored, 1 opens, 2 rejected
    int        lat;    // cycles from the valid cycle to the decision cycle
  } vec_t;

  vec_t      tab [12];
  senhaPac_t mslot [N];
  bit        ex_ten [NC];
  bit        ex_tr  [NC];
  bit        ex_er  [NC];
  bit        ex_bl  [NC];
  int        ex_tent [NC];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic senhaPac_t mk(input logic [79:0] v, input int n);
    senhaPac_t r = SENHA_VAZIA;
    for (int i = 0; i < n; i++) r[4*i +: 4] = v[4*i +: 4];
    return r;
  endfunction

  function automatic senhaPac_t rnd_entry(input int n);
    senhaPac_t r = SENHA_VAZIA;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 24) == 0) r[4*i +: 4] = 4'($urandom_range(10, 14));
      else                            r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Reference decision: index of the first slot equal to a well-formed entry, or -1.
  function automatic int decide(input senhaPac_t e);
    int  len = 0;
    bit  ok  = 1'b1;
    logic [3:0] d;
    for (int i = 0; i < 20; i++) begin
      d = e[4*i +: 4];
      if (d == 4'hF) break;
      if (d > 4'h9) ok = 1'b0;
      len++;
    end
    if (!ok || len < MIND || len > MAXD) return -1;
    for (int k = 0; k < N; k++) if (mslot[k] == e) return k;
    return -1;
  endfunction

  function automatic senhaPac_t pick_entry();
    int r = $urandom_range(0, 9);
    if (r == 0) return SENHA_CANCELA;
    if (r == 1) return SENHA_TIMEOUT;
    if (r <= 5) return mslot[$urandom_range(0, N-1)];
    return rnd_entry($urandom_range(2, 14));
  endfunction

  // Paint the expected output timeline caused by an entry accepted in cycle t.
  task automatic paint(input int t, input int k);
    int d, f, nt;
    if (k >= 0) begin
      d = t + k + 2;
      for (int c = t + 1; c < d + TAB; c++) ex_ten[c] = 1'b0;
      for (int c = d; c < d + TAB; c++) ex_tr[c] = 1'b1;
      for (int c = d; c < NC; c++) ex_tent[c] = 0;
    end else begin
      f = t + N + 1;
      for (int c = t + 1; c <= f; c++) ex_ten[c] = 1'b0;
      ex_er[f] = 1'b1;
      nt = (ex_tent[f] + 1 > MAXT) ? MAXT : ex_tent[f] + 1;
      for (int c = f + 1; c < NC; c++) ex_tent[c] = nt;
      if (nt == MAXT) begin
        for (int c = f + 1; c <= f + TBL; c++) begin
          ex_ten[c] = 1'b0;
          ex_bl[c]  = 1'b1;
        end
        for (int c = f + TBL + 1; c < NC; c++) ex_tent[c] = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    digitos_valid = 1'b0;
    cfg_we = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_slot(input int i, input senhaPac_t v);
    cfg_we = 1'b1;
    cfg_idx = 2'(i);
    cfg_senha = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic submit(input senhaPac_t e);
    digitos_value = e;
    digitos_valid = 1'b1;
    step();
    digitos_valid = 1'b0;
  endtask

  task automatic wait_decision(output int kind, output int lat, output int ten_min);
    kind = 0;
    lat = 0;
    ten_min = 1;
    for (int c = 1; c <= 12; c++) begin
      if (!teclado_en) ten_min = 0;
      if (tranca_abrir) begin kind = 1; lat = c; return; end
      if (erro)         begin kind = 2; lat = c; return; end
      step();
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!teclado_en && n < bound) begin
      step();
      n++;
    end
    if (!teclado_en) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string pre);
    check({pre, "_teclado_en"},   32'(teclado_en),   1);
    check({pre, "_tranca_abrir"}, 32'(tranca_abrir), 0);
    check({pre, "_erro"},         32'(erro),         0);
    check({pre, "_bloqueado"},    32'(bloqueado),    0);
    check({pre, "_tentativas"},   32'(tentativas),   0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, lat, tmin, n, aberto;
    senhaPac_t p, q;

    tab[0]  = '{mk(80'h1234, 4), 1, 2};
    tab[1]  = '{mk(80'h567890, 6), 1, 3};
    tab[2]  = '{mk(80'h123456789012, 12), 1, 4};
    tab[3]  = '{mk(80'h123, 3), 2, 5};
    tab[4]  = '{mk(80'h9999, 4), 2, 5};
    tab[5]  = '{mk(80'h12A4, 4), 2, 5};
    tab[6]  = '{mk(80'h1234567890123, 13), 2, 5};
    tab[7]  = '{mk(80'h12345, 5), 2, 5};
    tab[8]  = '{SENHA_CANCELA, 0, 0};
    tab[9]  = '{SENHA_TIMEOUT, 0, 0};
    tab[10] = '{mk(80'h01234, 5), 2, 5};
    tab[11] = '{mk(80'h11111111111111111111, 20), 2, 5};

    do_reset();
    check_reset_outputs("reset");

    // Directed table: fresh reset and slot set per row.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      load_slot(0, mk(80'h1234, 4));
      load_slot(1, mk(80'h567890, 6));
      load_slot(2, mk(80'h123456789012, 12));
      load_slot(3, mk(80'h123, 3));
      submit(tab[i].e);
      wait_decision(kind, lat, tmin);
      check($sformatf("vec%0d_kind", i), 32'(kind), 32'(tab[i].kind));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tab[i].lat));
      if (tab[i].kind == 0) begin
        check($sformatf("vec%0d_teclado_kept", i), 32'(tmin), 1);
        check($sformatf("vec%0d_tent", i), 32'(tentativas), 0);
      end else if (tab[i].kind == 2) begin
        step();
        check($sformatf("vec%0d_erro_single", i), 32'(erro), 0);
        check($sformatf("vec%0d_tent_after", i), 32'(tentativas), 1);
        check($sformatf("vec%0d_teclado_back", i), 32'(teclado_en), 1);
      end
    end

    // Open hold length, with a rewrite of the matching slot mid-open.
    do_reset();
    load_slot(0, mk(80'h1234, 4));
    submit(mk(80'h1234, 4));
    wait_decision(kind, lat, tmin);
    check("s1_kind", 32'(kind), 1);
    check("s1_lat", 32'(lat), 2);
    n = 0;
    while (tranca_abrir && n < TAB + 10) begin
      n++;
      if (n == 3) begin
        cfg_we = 1'b1;
        cfg_idx = 2'd0;
        cfg_senha = mk(80'h5555, 4);
      end else begin
        cfg_we = 1'b0;
      end
      step();
    end
    cfg_we = 1'b0;
    check("s1_open_cycles", 32'(n), TAB);
    check("s1_teclado_after", 32'(teclado_en), 1);
    check("s1_tent", 32'(tentativas), 0);

    // Three failures -> lockout; valid pulses during lockout are dropped.
    do_reset();
    load_slot(0, mk(80'h1234, 4));
    for (int j = 0; j < 3; j++) begin
      submit(mk(80'h9999, 4));
      wait_decision(kind, lat, tmin);
      check($sformatf("s3_fail%0d", j), 32'(kind), 2);
      if (j < 2) wait_idle(10);
    end
    step();
    check("s3_bloqueado", 32'(bloqueado), 1);
    check("s3_teclado_off", 32'(teclado_en), 0);
    check("s3_tent_max", 32'(tentativas), MAXT);
    n = 0;
    aberto = 0;
    while (bloqueado && n < TBL + 10) begin
      n++;
      if (tranca_abrir) aberto = 1;
      digitos_value = mk(80'h1234, 4);
      digitos_valid = 1'b1;
      step();
    end
    digitos_valid = 1'b0;
    check("s3_lock_cycles", 32'(n), TBL);
    check("s3_no_open", 32'(aberto), 0);
    check("s3_tent_cleared", 32'(tentativas), 0);
    check("s3_teclado_on", 32'(teclado_en), 1);
    step();
    check("s3_dropped_valid", 32'(teclado_en), 1);

    // Last slot only: decision latency and a same-cycle rewrite of the slot being compared.
    p = mk(80'h2468, 4);
    q = mk(80'h1357, 4);
    do_reset();
    load_slot(3, p);
    submit(p);
    wait_decision(kind, lat, tmin);
    check("s5_kind", 32'(kind), 1);
    check("s5_lat", 32'(lat), N + 1);
    wait_idle(TAB + 10);
    submit(p);
    step();
    step();
    step();
    cfg_we = 1'b1;
    cfg_idx = 2'd3;
    cfg_senha = q;
    step();
    cfg_we = 1'b0;
    check("s5_old_value", 32'(tranca_abrir), 1);
    wait_idle(TAB + 10);
    submit(p);
    wait_decision(kind, lat, tmin);
    check("s5_old_gone", 32'(kind), 2);
    wait_idle(10);
    submit(q);
    wait_decision(kind, lat, tmin);
    check("s5_new_value", 32'(kind), 1);

    // Reset during open and during lockout.
    do_reset();
    load_slot(0, mk(80'h1234, 4));
    submit(mk(80'h1234, 4));
    wait_decision(kind, lat, tmin);
    check("s6_open", 32'(kind), 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("s6_open_rst");
    submit(mk(80'h1234, 4));
    wait_decision(kind, lat, tmin);
    check("s6_slots_empty", 32'(kind), 2);
    for (int j = 0; j < 2; j++) begin
      wait_idle(10);
      submit(mk(80'h9999, 4));
      wait_decision(kind, lat, tmin);
    end
    step();
    check("s6_locked", 32'(bloqueado), 1);
    for (int j = 0; j < 5; j++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("s6_lock_rst");

    // Randomized phase against the timeline model.
    do_reset();
    for (int k = 0; k < N; k++) mslot[k] = SENHA_VAZIA;
    for (int c = 0; c < NC; c++) begin
      ex_ten[c] = 1'b1;
      ex_tr[c] = 1'b0;
      ex_er[c] = 1'b0;
      ex_bl[c] = 1'b0;
      ex_tent[c] = 0;
    end
    for (int t = 0; t < NR; t++) begin
      check("r_teclado_en",   32'(teclado_en),   32'(ex_ten[t]));
      check("r_tranca_abrir", 32'(tranca_abrir), 32'(ex_tr[t]));
      check("r_erro",         32'(erro),         32'(ex_er[t]));
      check("r_bloqueado",    32'(bloqueado),    32'(ex_bl[t]));
      check("r_tentativas",   32'(tentativas),   32'(ex_tent[t]));
      cfg_we = 1'b0;
      digitos_valid = 1'b0;
      if (ex_ten[t]) begin
        if ($urandom_range(0, 7) == 0) begin
          int k = $urandom_range(0, N-1);
          senhaPac_t s = rnd_entry($urandom_range(3, 13));
          cfg_we = 1'b1;
          cfg_idx = 2'(k);
          cfg_senha = s;
          mslot[k] = s;
        end
        if ($urandom_range(0, 3) == 0) begin
          senhaPac_t e = pick_entry();
          digitos_value = e;
          digitos_valid = 1'b1;
          if (e != SENHA_CANCELA && e != SENHA_TIMEOUT) paint(t, decide(e));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        digitos_value = pick_entry();
        digitos_valid = 1'b1;
      end
      step();
    end
    cfg_we = 1'b0;
    digitos_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
